rgmii_rx_frame_reader: RTL and testbench

RGMII_RX_FRAME_READER -- requirements
Module: rgmii_rx_frame_reader

---
 rtl/rgmii_rx_frame_reader.sv | 158 +++++++++++++++
 tb/tb_rgmii_rx_frame_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_frame_reader.sv
// Replays length-delimited frames from a frame RAM as a GMII-style byte stream,
// one frame per length-FIFO entry, with a minimum inter-frame gap.
module rgmii_rx_frame_reader #(
    parameter int P_RAM_LATENCY = 1,
    parameter int P_IFG_CYCLES  = 12,
    parameter int P_MAX_ADDR    = 1525
) (
    input  logic        i_udp_stack_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_len_fifo_empty,
    input  logic [10:0] i_len_fifo_dout,
    output logic        o_len_fifo_rden,
    output logic        o_ram_en,
    output logic [10:0] o_ram_addr,
    input  logic [7:0]  i_ram_dout,
    output logic [7:0]  o_gmii_rx_data,
    output logic        o_gmii_rx_valid,
    output logic        o_busy,
    output logic        o_len_err,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_LATCH, S_READ, S_DRAIN, S_GAP
    } t_state;

    localparam logic [15:0] LP_DRAIN_LAST = 16'(P_RAM_LATENCY);
    localparam logic [15:0] LP_GAP_LAST   = (P_IFG_CYCLES == 0) ? 16'd0 : 16'(P_IFG_CYCLES - 1);
    localparam logic [10:0] LP_MAX        = 11'(P_MAX_ADDR);

    t_state                   r_state;
    t_state                   w_next;
    logic                     r_armed;
    logic [10:0]              r_last;
    logic [10:0]              r_addr;
    logic [10:0]              r_emit;
    logic [15:0]              r_cnt;
    logic [15:0]              r_frame_cnt;
    logic                     r_len_err;
    logic [7:0]               r_data;
    // Bits [L-1:0] track the RAM read latency; the top bit is the output valid.
    logic [P_RAM_LATENCY:0]   r_en_dly;
    logic                     w_ram_en;
    logic                     w_rd_last;
    logic                     w_over;
    logic                     w_tap;

    assign w_rd_last = (r_state == S_READ) && (r_addr == r_last);
    assign w_over    = (i_len_fifo_dout > LP_MAX);
    assign w_tap     = r_en_dly[P_RAM_LATENCY-1];

    always_ff @(posedge i_udp_stack_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        o_len_fifo_rden = 1'b0;
        w_ram_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && i_enable && !i_len_fifo_empty) begin
                    w_next = S_POP;
                end
            end
            S_POP: begin
                o_len_fifo_rden = 1'b1;
                w_next          = S_LATCH;
            end
            S_LATCH: begin
                w_next = S_READ;
            end
            S_READ: begin
                w_ram_en = 1'b1;
                if (r_addr == r_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == LP_DRAIN_LAST) begin
                    if (P_IFG_CYCLES == 0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == LP_GAP_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_udp_stack_clk or posedge i_rst) begin
        if (i_rst) begin
            r_armed     <= 1'b0;
            r_last      <= '0;
            r_addr      <= '0;
            r_emit      <= '0;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            r_len_err   <= 1'b0;
            r_data      <= '0;
            r_en_dly    <= '0;
        end else begin
            r_armed   <= 1'b1;
            r_len_err <= 1'b0;
            if (r_state == S_LATCH) begin
                r_last    <= w_over ? LP_MAX : i_len_fifo_dout;
                r_len_err <= w_over;
            end

            if ((r_state == S_READ) && !w_rd_last) begin
                r_addr <= r_addr + 11'd1;
            end else begin
                r_addr <= '0;
            end

            if ((r_state == w_next) && ((r_state == S_DRAIN) || (r_state == S_GAP))) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end

            r_en_dly <= {r_en_dly[P_RAM_LATENCY-1:0], w_ram_en};
            r_data   <= w_tap ? i_ram_dout : '0;

            // Emitted-byte count identifies the last byte without a parallel flag pipeline.
            if (w_tap) begin
                if (r_emit == r_last) begin
                    r_emit      <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_emit <= r_emit + 11'd1;
                end
            end
        end
    end

    assign o_ram_en        = w_ram_en;
    assign o_ram_addr      = w_ram_en ? r_addr : '0;
    assign o_gmii_rx_data  = r_data;
    assign o_gmii_rx_valid = r_en_dly[P_RAM_LATENCY];
    assign o_busy          = (r_state != S_IDLE);
    assign o_len_err       = r_len_err;
    assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_rgmii_rx_frame_reader.sv
// Directed bench: latency-1 instance for frame sequencing, clamping, enable and reset;
// latency-2 instance for pipeline depth and busy duration.
`timescale 1ns/1ps
module tb_rgmii_rx_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ram_byte(input int a);
        return 8'(a * 7 + (a >> 8) + 3);
    endfunction

    // ---------------- instance A: latency 1 ----------------
    logic        rst_a = 1'b0, enable_a = 1'b0, empty_a = 1'b1;
    logic [10:0] fdout_a = '0, addr_a;
    logic        rden_a, ramen_a, val_a, busy_a, lerr_a;
    logic [7:0]  rdout_a = '0, data_a;
    logic [15:0] fcnt_a;
    logic [10:0] qa[$];

    rgmii_rx_frame_reader #(.P_RAM_LATENCY(1), .P_IFG_CYCLES(12), .P_MAX_ADDR(1525)) dut_a (
        .i_udp_stack_clk(clk), .i_rst(rst_a), .i_enable(enable_a),
        .i_len_fifo_empty(empty_a), .i_len_fifo_dout(fdout_a), .o_len_fifo_rden(rden_a),
        .o_ram_en(ramen_a), .o_ram_addr(addr_a), .i_ram_dout(rdout_a),
        .o_gmii_rx_data(data_a), .o_gmii_rx_valid(val_a), .o_busy(busy_a),
        .o_len_err(lerr_a), .o_frame_cnt(fcnt_a));

    always @(posedge clk) begin
        if (rden_a && qa.size() > 0) fdout_a <= qa.pop_front();
        empty_a <= (qa.size() == 0);
        if (ramen_a) rdout_a <= ram_byte(int'(addr_a));
    end

    int cyc = 0, e_addr = 0, en_cyc = 0, lat = 0, cur = 0, idle = 0, gap = 0;
    int nrden = 0, nlerr = 0, last_addr = 0, fc_m = 0;
    bit in_frm = 0;
    int flens[$];
    int gaps[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_a) begin
            e_addr = 0; cur = 0; in_frm = 0; fc_m = 0; idle = 0;
        end else begin
            if (rden_a) nrden++;
            if (lerr_a) nlerr++;
            if (ramen_a) begin
                if (e_addr == 0) en_cyc = cyc;
                chk("ram_addr", int'(addr_a), e_addr);
                last_addr = int'(addr_a);
                e_addr++;
            end else begin
                chk("addr_idle", int'(addr_a), 0);
                e_addr = 0;
            end
            if (val_a) begin
                if (!in_frm) begin
                    in_frm = 1; cur = 0; lat = cyc - en_cyc; gap = idle;
                end
                chk("rx_data", int'(data_a), int'(ram_byte(cur)));
                cur++;
                idle = 0;
            end else begin
                chk("data_idle", int'(data_a), 0);
                idle++;
                if (in_frm) begin
                    in_frm = 0;
                    flens.push_back(cur);
                    gaps.push_back(gap);
                    fc_m++;
                    chk("frame_cnt_track", int'(fcnt_a), fc_m);
                end
            end
        end
    end

    // ---------------- instance B: latency 2 ----------------
    logic        rst_b = 1'b0, enable_b = 1'b0, empty_b = 1'b1;
    logic [10:0] fdout_b = '0, addr_b;
    logic        rden_b, ramen_b, val_b, busy_b, lerr_b;
    logic [7:0]  rdout_b = '0, s1_b = '0, data_b;
    logic [15:0] fcnt_b;
    logic [10:0] qb[$];

    rgmii_rx_frame_reader #(.P_RAM_LATENCY(2), .P_IFG_CYCLES(12), .P_MAX_ADDR(1525)) dut_b (
        .i_udp_stack_clk(clk), .i_rst(rst_b), .i_enable(enable_b),
        .i_len_fifo_empty(empty_b), .i_len_fifo_dout(fdout_b), .o_len_fifo_rden(rden_b),
        .o_ram_en(ramen_b), .o_ram_addr(addr_b), .i_ram_dout(rdout_b),
        .o_gmii_rx_data(data_b), .o_gmii_rx_valid(val_b), .o_busy(busy_b),
        .o_len_err(lerr_b), .o_frame_cnt(fcnt_b));

    always @(posedge clk) begin
        if (rden_b && qb.size() > 0) fdout_b <= qb.pop_front();
        empty_b <= (qb.size() == 0);
        if (ramen_b) s1_b <= ram_byte(int'(addr_b));
        rdout_b <= s1_b;
    end

    int cyc_b = 0, en_cyc_b = 0, lat_b = 0, nbytes_b = 0, busy_fall_b = 0, nlerr_b = 0;
    bit busy_q_b = 0;

    always @(negedge clk) begin
        cyc_b++;
        if (!rst_b) begin
            if (lerr_b) nlerr_b++;
            if (ramen_b) begin
                en_cyc_b = cyc_b;
                chk("b_ram_addr", int'(addr_b), 0);
            end
            if (val_b) begin
                lat_b = cyc_b - en_cyc_b;
                nbytes_b++;
                chk("b_rx_data", int'(data_b), int'(ram_byte(0)));
            end
            if (busy_q_b && !busy_b) busy_fall_b = cyc_b - en_cyc_b;
            busy_q_b = busy_b;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done_a(input int fc, input int budget);
        int n = 0;
        while (!(fcnt_a == 16'(fc) && !busy_a) && n < budget) begin
            tick(1);
            n++;
        end
        chk("timeout_a", int'(n < budget), 1);
    endtask

    task automatic wait_bytes_a(input int k, input int budget);
        int n = 0;
        while (!(in_frm && cur >= k) && n < budget) begin
            tick(1);
            n++;
        end
        chk("timeout_bytes", int'(n < budget), 1);
    endtask

    function automatic int last_len();
        if (flens.size() == 0) return -1;
        return flens[flens.size()-1];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        chk("rst_valid", int'(val_a), 0);
        chk("rst_data", int'(data_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rden", int'(rden_a), 0);
        chk("rst_ram_en", int'(ramen_a), 0);
        chk("rst_fcnt", int'(fcnt_a), 0);
        chk("rst_lerr", int'(lerr_a), 0);
        tick(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        enable_a = 1'b1;
        enable_b = 1'b1;

        // single 64-byte frame
        qa.push_back(11'd63);
        wait_done_a(1, 400);
        chk("f1_len", last_len(), 64);
        chk("f1_latency", lat, 2);
        chk("f1_last_addr", last_addr, 63);
        chk("f1_rden", nrden, 1);
        chk("f1_fcnt", int'(fcnt_a), 1);
        chk("f1_lerr", nlerr, 0);

        // two queued frames, lengths 9 and 0
        qa.push_back(11'd9);
        qa.push_back(11'd0);
        wait_done_a(3, 600);
        chk("f2_len", flens[1], 10);
        chk("f3_len", flens[2], 1);
        chk("f3_ifg_ge15", int'(gaps[2] >= 15), 1);
        chk("f3_rden", nrden, 3);
        chk("f3_fcnt", int'(fcnt_a), 3);

        // oversize length is clamped
        qa.push_back(11'd2000);
        wait_done_a(4, 3000);
        chk("clamp_len", last_len(), 1526);
        chk("clamp_lerr", nlerr, 1);
        chk("clamp_last_addr", last_addr, 1525);
        chk("clamp_fcnt", int'(fcnt_a), 4);

        // enable dropped mid-frame
        qa.push_back(11'd99);
        qa.push_back(11'd5);
        wait_bytes_a(5, 200);
        enable_a = 1'b0;
        wait_done_a(5, 400);
        tick(40);
        chk("en_len", last_len(), 100);
        chk("en_no_pop", nrden, 5);
        chk("en_idle", int'(busy_a), 0);
        chk("en_queue", qa.size(), 1);
        enable_a = 1'b1;
        wait_done_a(6, 200);
        chk("en_resume_len", last_len(), 6);
        chk("en_resume_rden", nrden, 6);

        // reset mid-frame
        qa.push_back(11'd99);
        qa.push_back(11'd30);
        wait_bytes_a(20, 200);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_valid", int'(val_a), 0);
        chk("mid_rst_data", int'(data_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_fcnt", int'(fcnt_a), 0);
        tick(1);
        rst_a = 1'b0;
        wait_done_a(1, 300);
        chk("post_rst_len", last_len(), 31);
        chk("post_rst_rden", nrden, 8);
        chk("post_rst_queue", qa.size(), 0);

        // latency-2 instance, 1-byte frame
        qb.push_back(11'd0);
        begin
            int n = 0;
            while (!(fcnt_b == 16'd1 && !busy_b) && n < 200) begin
                tick(1);
                n++;
            end
            chk("timeout_b", int'(n < 200), 1);
        end
        chk("b_latency", lat_b, 3);
        chk("b_bytes", nbytes_b, 1);
        chk("b_busy_fall", busy_fall_b, 16);
        chk("b_fcnt", int'(fcnt_b), 1);
        chk("b_lerr", nlerr_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
